// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 transmitter with TX FIFO and idle interrupt.
// Define UART_PARITY_EN to add a parity bit (CTRL bit1 PEN, bit2 ODD).
module uart_tx_dev #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd433
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] DEV_Addr,
   input  logic [31:0] DEV_WD,
   input  logic        DEV_WE,
   output logic [31:0] DEV_RD,
   output logic        intrp,
   output logic        tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULLC = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          ovf, ie;
   logic [15:0]   div, bcnt;
   logic [7:0]    shreg, head;
   logic [2:0]    bitn;
   logic          pen, odd, fpen, fpar;
   logic          wr_data, wr_stat, wr_ctrl, wr_div;
   logic          empty, full, busy, bnd, pop, push;
   logic          unused_ok;

   assign unused_ok = ^{DEV_Addr[31:4], DEV_Addr[1:0], DEV_WD[31:16]};

   assign wr_data = DEV_WE & (DEV_Addr[3:2] == 2'd0);
   assign wr_stat = DEV_WE & (DEV_Addr[3:2] == 2'd1);
   assign wr_ctrl = DEV_WE & (DEV_Addr[3:2] == 2'd2);
   assign wr_div  = DEV_WE & (DEV_Addr[3:2] == 2'd3);

   assign empty = (count == '0);
   assign full  = (count == FULLC);
   assign busy  = (state != IDLE);
   assign bnd   = (bcnt == 16'd0);
   assign head  = mem[rptr];
   // a full FIFO still takes a push when the shifter drains it this cycle
   assign pop   = ~empty & ((state == IDLE) | ((state == STOP) & bnd));
   assign push  = wr_data & (~full | pop);

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= DEV_WD[7:0];
   end

`ifdef UART_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pen <= 1'b0;
         odd <= 1'b0;
      end else if (wr_ctrl) begin
         pen <= DEV_WD[1];
         odd <= DEV_WD[2];
      end
   end
`else
   assign pen = 1'b0;
   assign odd = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         ie    <= 1'b0;
         div   <= DIV_RESET;
         intrp <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         if (push & ~pop)
            count <= count + ONE;
         else if (~push & pop)
            count <= count - ONE;
         if (wr_data & ~push)
            ovf <= 1'b1;
         else if (wr_stat)
            ovf <= 1'b0;
         if (wr_ctrl)
            ie <= DEV_WD[0];
         if (wr_div)
            div <= DEV_WD[15:0];
         intrp <= ie & empty & ~busy;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         tx    <= 1'b1;
         bcnt  <= '0;
         shreg <= '0;
         bitn  <= '0;
         fpen  <= 1'b0;
         fpar  <= 1'b0;
      end else if (pop) begin
         state <= START;
         tx    <= 1'b0;
         bcnt  <= div;
         shreg <= head;
         bitn  <= '0;
         fpen  <= pen;
         fpar  <= (^head) ^ odd;
      end else if (state != IDLE) begin
         if (!bnd) begin
            bcnt <= bcnt - 16'd1;
         end else begin
            bcnt <= div;
            case (state)
               START: begin
                  state <= DATA;
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
               end
               DATA: begin
                  if (bitn != 3'd7) begin
                     tx    <= shreg[0];
                     shreg <= shreg >> 1;
                     bitn  <= bitn + 3'd1;
                  end else if (fpen) begin
                     state <= PARITY;
                     tx    <= fpar;
                  end else begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end
               end
               PARITY: begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
               default: begin
                  state <= IDLE;
                  tx    <= 1'b1;
               end
            endcase
         end
      end
   end

   always_comb begin
      DEV_RD = '0;
      unique case (DEV_Addr[3:2])
         2'd0: DEV_RD = '0;
         2'd1: DEV_RD = {23'b0, ovf, busy, full, empty, 5'(count)};
         2'd2: DEV_RD = {29'b0, odd, pen, ie};
         2'd3: DEV_RD = {16'b0, div};
      endcase
   end
endmodule
